data_upload: RTL and testbench
==============================

Name: data_upload

Overview:
- SPI slave that streams emulator memory back to the IO controller on the same select (SPI_SS2) used for ROM download. It is the reverse direction of the existing download path.
- Used for save-to-SD of tape/RAM images.
- Oversamples SCK/SS/SDI in the system clock domain, decodes upload commands and fetches bytes from a memory port with a req/ack handshake.
- Shifts data out MSB-first on SDO.
- Sits between the SPI pins (sharing SPI_DO with user_io) and the SDRAM arbiter.

Parameters:
- ADDR_W, 25, width of memory read address.
- BASE_ADDR, 25'h0, first address read after UPLOAD_START.
- CMD_START, 8'h56, command: begin upload; next byte = index.
- CMD_DATA, 8'h57, command: stream data bytes.
- CMD_END, 8'h58, command: end upload.

Ports:
- clk  in  1  system clock; must be >= 8x SCK frequency.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock (async).
- ss  in  1  SPI select, active low (async).
- sdi  in  1  SPI data from IO controller (async).
- sdo  out  1  SPI data to IO controller.
- sdo_en  out  1  high when sdo is to be driven; low means top level tristates.
- uploading  out  1  high between START and END.
- upload_index  out  8  index byte received with START.
- rd_req  out  1  memory read request, level, held until ack.
- rd_addr  out  ADDR_W  read address, stable while rd_req=1.
- rd_ack  in  1  one-cycle pulse; rd_data valid this cycle.
- rd_data  in  8  read data.
- underrun  out  1  sticky: a data slot had no byte ready.
- byte_count  out  ADDR_W  data bytes shifted out since START.

Behaviour:
- Reset values: sdo=1, sdo_en=0, uploading=0, upload_index=0, rd_req=0, rd_addr=BASE_ADDR, underrun=0, byte_count=0, FSM=IDLE, prefetch buffer invalid.
- Synchronisers: 2-flop on sck, ss and sdi, plus edge detect on synced sck and ss. All logic is on clk. Latency from pin to edge event is 3 clk.
- SPI mode 0:
  - sdi is sampled on the sck rising event.
  - sdo is updated on the sck falling event.
  - Bit 7 of a newly loaded byte is on sdo at the load cycle.
- Transaction:
  - ss falling resets bit counter to 0 and sets FSM=CMD.
  - sdo_en = (synced ss==0).
  - ss rising at any time discards the partial byte, sets FSM=IDLE and sdo=1.
  - uploading, rd_addr, byte_count and the prefetch buffer persist across transactions.
- States: IDLE, CMD, INDEX, TURN, DATA, SKIP.
- Transitions on a complete received byte (8th rising event):
  - CMD, byte==CMD_START -> INDEX.
  - CMD, byte==CMD_DATA and uploading=1 -> TURN.
  - CMD, byte==CMD_END -> SKIP, with uploading=0.
  - CMD, any other byte (or DATA while not uploading) -> SKIP.
  - INDEX byte -> upload_index<=byte, uploading=1, rd_addr=BASE_ADDR, byte_count=0, underrun=0, prefetch invalidated, any pending read abandoned only after its ack. Then -> SKIP.
  - TURN byte ends -> DATA.
  - DATA byte ends -> stays in DATA.
- Output during slots:
  - During CMD, INDEX and TURN, sdo shifts 0x00.
  - At each DATA slot start (falling event after the previous slot's 8th rising edge):
    - If prefetch is valid, load it, invalidate it, byte_count+1 and rd_addr+1.
    - Otherwise load 0xFF, set underrun=1, byte_count+1 and rd_addr+1 (the slot is consumed).
- Prefetch:
  - Whenever uploading=1, FSM is TURN or DATA, prefetch is invalid and rd_req=0, assert rd_req with the current rd_addr.
  - On rd_ack, latch rd_data into prefetch (valid=1) and drop rd_req in the same cycle.
  - A read outstanding at ss rising completes normally and its byte stays valid for the next CMD_DATA transaction.
- Width: rd_addr and byte_count wrap modulo 2^ADDR_W silently.
- rd_ack while rd_req=0 is ignored.
- Async reset mid-transfer forces all reset values immediately. Any in-flight memory read is abandoned.

Test Plan:
- Reset then idle, ss=1 -> sdo_en=0, rd_req=0, uploading=0, all counters 0.
- ss low, send 0x56, 0x03, ss high -> uploading=1, upload_index=0x03, rd_addr=0, sdo shifted 0x00,0x00.
- Memory holds A5,3C,F0 at 0..2 with 4-clk ack latency. Send 0x57 plus 4 dummy bytes -> sdo bytes 00,00,A5,3C,F0; byte_count=3; underrun=0.
- Ack latency longer than one byte time -> affected slot reads 0xFF, underrun=1; next START clears underrun.
- ss high mid-DATA byte (bit 4), then new 0x57 transaction -> partial byte dropped, stream resumes at the next address with no duplicate or skip.
- Send 0x58 -> uploading=0. A following 0x57 -> FSM SKIP, rd_req stays 0. reset_n pulse mid-byte -> all outputs return to reset values within 1 clk.

Source files
------------

// File: rtl/data_upload_if.sv
// Memory read port between data_upload (master) and the SDRAM arbiter (slave).
//   rd_req   master->slave  level request, held until rd_ack
//   rd_addr  master->slave  read address, stable while rd_req=1
//   rd_ack   slave->master  one-cycle pulse, rd_data valid in that cycle
//   rd_data  slave->master  read byte
interface data_upload_if #(
  parameter int ADDR_W = 25
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [7:0]        rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/data_upload.sv
// SPI slave (mode 0) streaming emulator memory back to the IO controller.
// SCK/SS/SDI are oversampled on clk; upload commands are decoded and data
// bytes are prefetched from a req/ack memory port, then shifted out MSB first.
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   sck, ss, sdi            SPI pins from the IO controller (asynchronous)
//   sdo, sdo_en             SPI data out and its drive enable
//   uploading, upload_index upload session flag and index byte from START
//   underrun                sticky: a data slot found no byte ready
//   byte_count              data bytes shifted out since START
//   mem                     memory read port (master side)
module data_upload #(
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]        CMD_START = 8'h56,
  parameter logic [7:0]        CMD_DATA  = 8'h57,
  parameter logic [7:0]        CMD_END   = 8'h58
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_en,
  output logic              uploading,
  output logic [7:0]        upload_index,
  output logic              underrun,
  output logic [ADDR_W-1:0] byte_count,
  data_upload_if.master     mem
);

  typedef enum logic [2:0] {IDLE, CMD, INDEX, TURN, DATA, SKIP} state_t;
  state_t state_reg, state_next;

  logic [2:0]        sck_sync_reg, ss_sync_reg;
  logic [1:0]        sdi_sync_reg;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        rx_reg, tx_reg, pf_data_reg, index_reg;
  logic              slot_pend_reg, uploading_reg, underrun_reg;
  logic              rd_req_reg, stale_reg, pf_valid_reg;
  logic [ADDR_W-1:0] next_addr_reg, req_addr_reg, byte_count_reg;

  logic       sck_rise, sck_fall, ss_rise, ss_fall, live;
  logic [7:0] rx_byte, slot_byte;
  logic       byte_done, restart, load_slot, ack_hit, ack_good, issue_req, stale_set;

  // Bit [1] is the synchronised level, bit [2] its previous value.
  assign sck_rise = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign sck_fall = ~sck_sync_reg[1] & sck_sync_reg[2];
  assign ss_rise  = ss_sync_reg[1] & ~ss_sync_reg[2];
  assign ss_fall  = ~ss_sync_reg[1] & ss_sync_reg[2];
  // A deselect in the same cycle as a bit event wins: the byte is dropped.
  assign live     = (state_reg != IDLE) & ~ss_rise;
  assign rx_byte  = {rx_reg[6:0], sdi_sync_reg[1]};
  assign ack_hit  = mem.rd_ack & rd_req_reg;
  // A read issued before a restart or an underrun belongs to an address
  // that is no longer wanted; its data is dropped when it lands.
  assign ack_good = ack_hit & ~stale_reg;

  always_comb begin
    state_next = state_reg;
    byte_done  = live & sck_rise & (bit_cnt_reg == 3'd7);
    restart    = byte_done & (state_reg == INDEX);
    load_slot  = live & sck_fall & slot_pend_reg & (state_reg == DATA);
    // An ack landing exactly at slot start is forwarded straight out.
    slot_byte  = 8'hFF;
    if (pf_valid_reg)  slot_byte = pf_data_reg;
    else if (ack_good) slot_byte = mem.rd_data;
    issue_req  = ~rd_req_reg & uploading_reg & ~pf_valid_reg & ~load_slot &
                 ((state_reg == TURN) | (state_reg == DATA));
    stale_set  = rd_req_reg & ~ack_hit & (restart | (load_slot & ~pf_valid_reg));

    if (ss_rise) begin
      state_next = IDLE;
    end else if (ss_fall) begin
      state_next = CMD;
    end else if (byte_done) begin
      case (state_reg)
        CMD: begin
          if (rx_byte == CMD_START)                        state_next = INDEX;
          else if ((rx_byte == CMD_DATA) && uploading_reg) state_next = TURN;
          else                                             state_next = SKIP;
        end
        INDEX:   state_next = SKIP;
        TURN:    state_next = DATA;
        DATA:    state_next = DATA;
        SKIP:    state_next = SKIP;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_reg <= 3'b000;
      ss_sync_reg  <= 3'b111;  // idle-deselected so no spurious select edge
      sdi_sync_reg <= 2'b00;
      state_reg    <= IDLE;
    end else begin
      sck_sync_reg <= {sck_sync_reg[1:0], sck};
      ss_sync_reg  <= {ss_sync_reg[1:0], ss};
      sdi_sync_reg <= {sdi_sync_reg[0], sdi};
      state_reg    <= state_next;
    end
  end

  // Shift path. slot_pend marks that the next falling event opens a new
  // byte slot rather than shifting the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg   <= 3'd0;
      rx_reg        <= 8'h00;
      tx_reg        <= 8'hFF;
      slot_pend_reg <= 1'b0;
    end else if (ss_rise) begin
      bit_cnt_reg   <= 3'd0;
      slot_pend_reg <= 1'b0;
      tx_reg        <= 8'hFF;
    end else if (ss_fall) begin
      bit_cnt_reg   <= 3'd0;
      slot_pend_reg <= 1'b0;
      tx_reg        <= 8'h00;
    end else if (live) begin
      if (sck_rise) begin
        rx_reg      <= rx_byte;
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) slot_pend_reg <= 1'b1;
      end
      if (sck_fall) begin
        if (slot_pend_reg) begin
          slot_pend_reg <= 1'b0;
          tx_reg        <= (state_reg == DATA) ? slot_byte : 8'h00;
        end else begin
          tx_reg <= {tx_reg[6:0], 1'b0};
        end
      end
    end
  end

  // Upload session state; persists across SPI transactions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uploading_reg  <= 1'b0;
      index_reg      <= 8'h00;
      underrun_reg   <= 1'b0;
      byte_count_reg <= '0;
      next_addr_reg  <= BASE_ADDR;
    end else begin
      if (byte_done && (state_reg == CMD) && (rx_byte == CMD_END)) uploading_reg <= 1'b0;
      if (restart) begin
        uploading_reg  <= 1'b1;
        index_reg      <= rx_byte;
        underrun_reg   <= 1'b0;
        byte_count_reg <= '0;
        next_addr_reg  <= BASE_ADDR;
      end else if (load_slot) begin
        // The slot is consumed whether or not a byte was ready.
        byte_count_reg <= byte_count_reg + ADDR_W'(1);
        next_addr_reg  <= next_addr_reg + ADDR_W'(1);
        if (!pf_valid_reg && !ack_good) underrun_reg <= 1'b1;
      end
    end
  end

  // Single-entry prefetch buffer and its read request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_reg   <= 1'b0;
      req_addr_reg <= BASE_ADDR;
      stale_reg    <= 1'b0;
      pf_valid_reg <= 1'b0;
      pf_data_reg  <= 8'h00;
    end else begin
      if (ack_hit) begin
        rd_req_reg <= 1'b0;
        stale_reg  <= 1'b0;
      end else if (issue_req) begin
        rd_req_reg   <= 1'b1;
        req_addr_reg <= next_addr_reg;
      end
      if (stale_set) stale_reg <= 1'b1;
      if (restart || load_slot) begin
        pf_valid_reg <= 1'b0;
      end else if (ack_good) begin
        pf_valid_reg <= 1'b1;
        pf_data_reg  <= mem.rd_data;
      end
    end
  end

  assign sdo          = tx_reg[7];
  assign sdo_en       = ~ss_sync_reg[1];
  assign uploading    = uploading_reg;
  assign upload_index = index_reg;
  assign underrun     = underrun_reg;
  assign byte_count   = byte_count_reg;
  assign mem.rd_req   = rd_req_reg;
  // Show the in-flight address while requesting, else the next slot address.
  assign mem.rd_addr  = rd_req_reg ? req_addr_reg : next_addr_reg;

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload: drives SPI mode 0 transactions, models the
// memory port with programmable ack latency, and checks every shifted-out
// byte against a scoreboard of expected bytes.
module tb_data_upload;
  localparam int ADDR_W = 25;

  logic              clk, reset_n, sck, ss, sdi;
  logic              sdo, sdo_en, uploading, underrun;
  logic [7:0]        upload_index;
  logic [ADDR_W-1:0] byte_count;

  data_upload_if #(.ADDR_W(ADDR_W)) mem_if ();

  data_upload #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
    .sdo(sdo), .sdo_en(sdo_en), .uploading(uploading),
    .upload_index(upload_index), .underrun(underrun),
    .byte_count(byte_count), .mem(mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         lat      = 4;
  int         req_cycles = 0;
  int         resp_lat;
  logic [ADDR_W-1:0] resp_addr;
  logic [7:0] mem_arr [0:15];
  logic [7:0] exp_q [$];

  // Memory responder: sees rd_req on a falling clk edge, acks lat cycles later.
  initial begin
    mem_if.rd_ack  = 1'b0;
    mem_if.rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_if.rd_req === 1'b1) begin
        resp_addr = mem_if.rd_addr;
        resp_lat  = lat;
        repeat (resp_lat - 1) @(negedge clk);
        mem_if.rd_data = mem_arr[resp_addr[3:0]];
        mem_if.rd_ack  = 1'b1;
        @(negedge clk);
        mem_if.rd_ack  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_if.rd_req === 1'b1) req_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sdo"},       32'(sdo), 32'h1);
    check({tag, "_sdo_en"},    32'(sdo_en), 32'h0);
    check({tag, "_uploading"}, 32'(uploading), 32'h0);
    check({tag, "_index"},     32'(upload_index), 32'h0);
    check({tag, "_rd_req"},    32'(mem_if.rd_req), 32'h0);
    check({tag, "_rd_addr"},   32'(mem_if.rd_addr), 32'h0);
    check({tag, "_underrun"},  32'(underrun), 32'h0);
    check({tag, "_byte_cnt"},  32'(byte_count), 32'h0);
  endtask

  // One bit = 8 clk with sck low then 8 clk with sck high; sdo is sampled
  // just before the rising edge. sck is left high after the last bit.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b0;
      sdi = tx[7-i];
      repeat (8) @(negedge clk);
      rx[7-i] = sdo;
      sck = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] tx, input logic [7:0] expv);
    logic [7:0] rx;
    logic [7:0] e;
    exp_q.push_back(expv);
    xfer(tx, 8, rx);
    e = exp_q.pop_front();
    $display("txn: sent %02h got %02h expected %02h", tx, rx, e);
    check("sdo_byte", 32'(rx), 32'(e));
  endtask

  task automatic begin_txn();
    ss = 1'b0;
    repeat (8) @(negedge clk);
    check("sdo_en_sel", 32'(sdo_en), 32'h1);
  endtask

  // Deselect while sck is still high so no trailing falling edge opens a slot.
  task automatic end_txn();
    ss = 1'b1;
    repeat (8) @(negedge clk);
    sck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    int r0;
    reset_n = 1'b0; sck = 1'b0; ss = 1'b1; sdi = 1'b0;
    for (int i = 0; i < 16; i++) mem_arr[i] = 8'h10 + 8'(i);
    mem_arr[0] = 8'hA5; mem_arr[1] = 8'h3C; mem_arr[2] = 8'hF0;

    repeat (3) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check_reset("idle");

    // START with index 3
    begin_txn();
    send_byte(8'h56, 8'h00);
    send_byte(8'h03, 8'h00);
    end_txn();
    check("start_uploading", 32'(uploading), 32'h1);
    check("start_index", 32'(upload_index), 32'h03);
    check("start_rd_addr", 32'(mem_if.rd_addr), 32'h0);

    // Stream three bytes with short ack latency
    begin_txn();
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, mem_arr[0]);
    send_byte(8'h00, mem_arr[1]);
    send_byte(8'h00, mem_arr[2]);
    end_txn();
    check("stream_byte_cnt", 32'(byte_count), 32'd3);
    check("stream_underrun", 32'(underrun), 32'h0);
    repeat (20) @(negedge clk);
    check("stream_rd_addr", 32'(mem_if.rd_addr), 32'd3);
    check("stream_rd_req", 32'(mem_if.rd_req), 32'h0);

    // Long ack latency: the second data slot underruns
    lat = 300;
    begin_txn();
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, mem_arr[3]);
    send_byte(8'h00, 8'hFF);
    end_txn();
    lat = 4;
    check("ur_underrun", 32'(underrun), 32'h1);
    check("ur_byte_cnt", 32'(byte_count), 32'd5);
    repeat (400) @(negedge clk);

    // Deselect at bit 4 of a data byte
    begin_txn();
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    xfer(8'h00, 4, rx);
    check("partial_nibble", 32'(rx[7:4]), 32'(mem_arr[5][7:4]));
    end_txn();
    check("partial_byte_cnt", 32'(byte_count), 32'd6);

    // Resume: next address, no duplicate
    begin_txn();
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, mem_arr[6]);
    end_txn();
    repeat (20) @(negedge clk);
    check("resume_byte_cnt", 32'(byte_count), 32'd7);
    check("resume_rd_addr", 32'(mem_if.rd_addr), 32'd7);
    check("resume_underrun", 32'(underrun), 32'h1);

    // New START clears underrun and restarts at base
    begin_txn();
    send_byte(8'h56, 8'h00);
    send_byte(8'h09, 8'h00);
    end_txn();
    check("restart_underrun", 32'(underrun), 32'h0);
    check("restart_index", 32'(upload_index), 32'h09);
    check("restart_byte_cnt", 32'(byte_count), 32'd0);
    check("restart_rd_addr", 32'(mem_if.rd_addr), 32'd0);

    begin_txn();
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, mem_arr[0]);
    end_txn();
    check("restart_stream_cnt", 32'(byte_count), 32'd1);

    // END, then DATA while not uploading must not touch memory
    begin_txn();
    send_byte(8'h58, 8'h00);
    end_txn();
    check("end_uploading", 32'(uploading), 32'h0);
    repeat (20) @(negedge clk);
    r0 = req_cycles;
    begin_txn();
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, 8'h00);
    end_txn();
    check("skip_no_req", 32'(req_cycles - r0), 32'd0);
    check("skip_byte_cnt", 32'(byte_count), 32'd1);

    // Reset in the middle of a data byte
    begin_txn();
    send_byte(8'h56, 8'h00);
    send_byte(8'h22, 8'h00);
    end_txn();
    check("idx2_index", 32'(upload_index), 32'h22);
    begin_txn();
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, mem_arr[0]);
    xfer(8'h00, 4, rx);
    check("pre_reset_nibble", 32'(rx[7:4]), 32'(mem_arr[1][7:4]));
    check("pre_reset_byte_cnt", 32'(byte_count), 32'd2);
    reset_n = 1'b0;
    #1;
    check_reset("mid_reset");
    ss = 1'b1; sck = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_reset("post_reset");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
